// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down saturating counter.
package counter_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SAT_HI = 2'd1,
        SAT_LO = 2'd2
    } cnt_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int clamp_val(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/counter_updown_sat.sv
// Parametrised up/down counter with programmable bounds, saturate/wrap mode and event flags.
// Optional sticky interrupt output enabled by defining COUNTER_UPDOWN_SAT_IRQ_EN.
module counter_updown_sat
    import counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int RESET_VAL = MIN_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] match_val,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             match_hit,
    output logic             at_max,
    output logic             at_min,
    output logic             wrapped,
`ifdef COUNTER_UPDOWN_SAT_IRQ_EN
    input  logic             irq_ack,
    output logic             irq,
`endif
    output logic             saturated
);

    localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MIN_X   = {1'b0, MIN_C};
    localparam logic [WIDTH:0]   MAX_X   = {1'b0, MAX_C};
    localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};

    cnt_state_t       state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   inc, dec;
    logic             wrap_nxt;
    logic             hit_nxt;

    // One extra bit keeps step arithmetic free of silent overflow at the top of the range.
    assign inc          = {1'b0, count} + ONE_X;
    assign dec          = {1'b0, count} - ONE_X;
    assign load_clamped = WIDTH'(clamp_val(int'(load_val), MIN_VAL, MAX_VAL));

    always_comb begin
        count_nxt = count;
        state_nxt = state;
        wrap_nxt  = 1'b0;
        if (clear) begin
            count_nxt = RESET_C;
            state_nxt = RUN;
        end else if (load) begin
            count_nxt = load_clamped;
            state_nxt = RUN;
            if (!wrap_mode && load_clamped == MAX_C)
                state_nxt = SAT_HI;
            else if (!wrap_mode && load_clamped == MIN_C)
                state_nxt = SAT_LO;
        end else begin
            case (state)
                RUN: begin
                    if (en && dir == DIR_UP) begin
                        if (count == MAX_C) begin
                            if (wrap_mode) begin
                                count_nxt = MIN_C;
                                wrap_nxt  = 1'b1;
                            end else begin
                                state_nxt = SAT_HI;
                            end
                        end else begin
                            count_nxt = inc[WIDTH-1:0];
                            if (!wrap_mode && inc == MAX_X)
                                state_nxt = SAT_HI;
                        end
                    end else if (en && dir == DIR_DOWN) begin
                        if (count == MIN_C) begin
                            if (wrap_mode) begin
                                count_nxt = MAX_C;
                                wrap_nxt  = 1'b1;
                            end else begin
                                state_nxt = SAT_LO;
                            end
                        end else begin
                            count_nxt = dec[WIDTH-1:0];
                            if (!wrap_mode && dec == MIN_X)
                                state_nxt = SAT_LO;
                        end
                    end
                end
                // Leaving saturation because wrap mode was switched on costs one idle edge.
                SAT_HI: begin
                    if (wrap_mode) begin
                        state_nxt = RUN;
                    end else if (en && dir == DIR_DOWN) begin
                        count_nxt = dec[WIDTH-1:0];
                        state_nxt = (dec == MIN_X) ? SAT_LO : RUN;
                    end
                end
                SAT_LO: begin
                    if (wrap_mode) begin
                        state_nxt = RUN;
                    end else if (en && dir == DIR_UP) begin
                        count_nxt = inc[WIDTH-1:0];
                        state_nxt = (inc == MAX_X) ? SAT_HI : RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // A hit needs the count to actually move onto match_val; clear never raises it.
    assign hit_nxt = !clear && (count_nxt != count) && (count_nxt == match_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= RESET_C;
            state     <= RUN;
            match_hit <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            count     <= count_nxt;
            state     <= state_nxt;
            match_hit <= hit_nxt;
            wrapped   <= wrap_nxt;
        end
    end

`ifdef COUNTER_UPDOWN_SAT_IRQ_EN
    // Set is taken from the same edge that raises the pulses so it beats a coincident ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (hit_nxt || wrap_nxt)
            irq <= 1'b1;
        else if (irq_ack || clear)
            irq <= 1'b0;
    end
`endif

    assign match     = (count == match_val);
    assign at_max    = (count == MAX_C);
    assign at_min    = (count == MIN_C);
    assign saturated = (state == SAT_HI) || (state == SAT_LO);

endmodule

// File: tb/tb_counter_updown_sat.sv
// Bench for counter_updown_sat: directed vector table, hand sequences and a randomized model check.
module tb_counter_updown_sat;

    typedef struct {
        bit clear, load;
        int lv;
        bit en, dir, wm;
        int mv;
        bit ack;
    } in_t;

    typedef struct {
        int  inst;
        in_t i;
        int  c;
        bit  hit, wr, sat;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic m, h, amax, amin, wr, sat, irq;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;

    logic       clear0, load0, en0, dir0, wm0, ack0;
    logic [2:0] lv0, mv0, count0;
    logic       match0, hit0, amax0, amin0, wr0, sat0, irq0;

    logic       clear1, load1, en1, dir1, wm1, ack1;
    logic [3:0] lv1, mv1, count1;
    logic       match1, hit1, amax1, amin1, wr1, sat1, irq1;

    int errors = 0;
    int checks = 0;

    int LO_B[2] = '{0, 2};
    int HI_B[2] = '{7, 10};
    int RS_B[2] = '{0, 2};
    int WM_B[2] = '{7, 15};

    int m_cnt[2];
    bit m_hi[2], m_lo[2], m_hit[2], m_wr[2], m_irq[2];
    bit wm_r[2];
    int mv_r[2];

    always #5 clk = ~clk;

    counter_updown_sat dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear0), .load(load0), .load_val(lv0),
        .en(en0), .dir(dir0), .wrap_mode(wm0), .match_val(mv0), .count(count0),
        .match(match0), .match_hit(hit0), .at_max(amax0), .at_min(amin0), .wrapped(wr0),
`ifdef COUNTER_UPDOWN_SAT_IRQ_EN
        .irq_ack(ack0), .irq(irq0),
`endif
        .saturated(sat0)
    );

    counter_updown_sat #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(10), .RESET_VAL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .load(load1), .load_val(lv1),
        .en(en1), .dir(dir1), .wrap_mode(wm1), .match_val(mv1), .count(count1),
        .match(match1), .match_hit(hit1), .at_max(amax1), .at_min(amin1), .wrapped(wr1),
`ifdef COUNTER_UPDOWN_SAT_IRQ_EN
        .irq_ack(ack1), .irq(irq1),
`endif
        .saturated(sat1)
    );

`ifndef COUNTER_UPDOWN_SAT_IRQ_EN
    assign irq0 = 1'b0;
    assign irq1 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int k, input in_t i);
        if (k == 0) begin
            clear0 = i.clear; load0 = i.load; lv0 = 3'(i.lv); en0 = i.en;
            dir0 = i.dir; wm0 = i.wm; mv0 = 3'(i.mv); ack0 = i.ack;
        end else begin
            clear1 = i.clear; load1 = i.load; lv1 = 4'(i.lv); en1 = i.en;
            dir1 = i.dir; wm1 = i.wm; mv1 = 4'(i.mv); ack1 = i.ack;
        end
    endtask

    function automatic out_t get_out(input int k);
        out_t o;
        if (k == 0) begin
            o.c = {29'd0, count0}; o.m = match0; o.h = hit0; o.amax = amax0;
            o.amin = amin0; o.wr = wr0; o.sat = sat0; o.irq = irq0;
        end else begin
            o.c = {28'd0, count1}; o.m = match1; o.h = hit1; o.amax = amax1;
            o.amin = amin1; o.wr = wr1; o.sat = sat1; o.irq = irq1;
        end
        return o;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = RS_B[k]; m_hi[k] = 0; m_lo[k] = 0;
            m_hit[k] = 0; m_wr[k] = 0; m_irq[k] = 0;
        end
    endfunction

    // Behavioural reference: count as an integer plus "pinned high/low" flags.
    function automatic void model_step(input int k, input in_t i);
        int lo = LO_B[k];
        int hi = HI_B[k];
        int c  = m_cnt[k];
        int nc = c;
        bit nh = m_hi[k];
        bit nl = m_lo[k];
        bit w  = 0;
        bit hit;
        if (i.clear) begin
            nc = RS_B[k]; nh = 0; nl = 0;
        end else if (i.load) begin
            nc = (i.lv < lo) ? lo : ((i.lv > hi) ? hi : i.lv);
            nh = !i.wm && nc == hi;
            nl = !i.wm && nc == lo;
        end else if ((m_hi[k] || m_lo[k]) && i.wm) begin
            nh = 0; nl = 0;
        end else if (i.en && i.dir) begin
            if (!m_hi[k]) begin
                if (c == hi) begin
                    if (i.wm) begin nc = lo; w = 1; end
                    else nh = 1;
                end else begin
                    nc = c + 1; nl = 0; nh = !i.wm && nc == hi;
                end
            end
        end else if (i.en) begin
            if (!m_lo[k]) begin
                if (c == lo) begin
                    if (i.wm) begin nc = hi; w = 1; end
                    else nl = 1;
                end else begin
                    nc = c - 1; nh = 0; nl = !i.wm && nc == lo;
                end
            end
        end
        hit = !i.clear && nc != c && nc == i.mv;
        m_irq[k] = hit || w || (m_irq[k] && !(i.ack || i.clear));
        m_cnt[k] = nc; m_hi[k] = nh; m_lo[k] = nl; m_hit[k] = hit; m_wr[k] = w;
    endfunction

    task automatic cycle(input in_t a, input in_t b);
        drive(0, a);
        drive(1, b);
        @(posedge clk);
        model_step(0, a);
        model_step(1, b);
        @(negedge clk);
    endtask

    function automatic in_t mk(input bit clr, input bit ld, input int lv, input bit en,
                               input bit dir, input bit wm, input int mv, input bit ack);
        in_t i;
        i.clear = clr; i.load = ld; i.lv = lv; i.en = en;
        i.dir = dir; i.wm = wm; i.mv = mv; i.ack = ack;
        return i;
    endfunction

    function automatic vec_t row(input int inst, input bit clr, input bit ld, input int lv,
                                 input bit en, input bit dir, input bit wm, input int mv,
                                 input int c, input bit hit, input bit wr, input bit sat);
        vec_t v;
        v.inst = inst; v.i = mk(clr, ld, lv, en, dir, wm, mv, 1'b0);
        v.c = c; v.hit = hit; v.wr = wr; v.sat = sat;
        return v;
    endfunction

    function automatic in_t rnd_in(input int k);
        in_t i;
        if ($urandom_range(0, 9) == 0) wm_r[k] = !wm_r[k];
        if ($urandom_range(0, 7) == 0) mv_r[k] = $urandom_range(0, WM_B[k]);
        i.clear = ($urandom_range(0, 15) == 0);
        i.load  = ($urandom_range(0, 7) == 0);
        i.lv    = $urandom_range(0, WM_B[k]);
        i.en    = ($urandom_range(0, 3) != 0);
        i.dir   = 1'($urandom_range(0, 1));
        i.wm    = wm_r[k];
        i.mv    = mv_r[k];
        i.ack   = ($urandom_range(0, 3) == 0);
        return i;
    endfunction

    vec_t tbl[$];
    vec_t v;
    out_t o;
    in_t  idle, u;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        drive(0, idle);
        drive(1, idle);
        model_reset();
        wm_r = '{0, 0};
        mv_r = '{0, 0};

        // Test plan 1: count up, saturate at 7 with a single hit at 4.
        for (int n = 1; n <= 10; n++)
            tbl.push_back(row(0, 0, 0, 0, 1, 1, 0, 4, (n > 7) ? 7 : n, n == 4, 0, n >= 7));
        // Test plan 2: wrap mode up through 7 -> 0, then down through 0 -> 7.
        tbl.push_back(row(0, 1, 0, 0, 1, 1, 1, 4, 0, 0, 0, 0));
        for (int n = 1; n <= 7; n++)
            tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 4, n, n == 4, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 4, 0, 0, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 4, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 4, 7, 0, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 4, 7, 0, 0, 0));
        // Saturate from RUN at max, then clear beats load; match_hit behaviour on holds.
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 0, 4, 7, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 5, 0, 0, 0, 5, 5, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 6, 5, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 7, 0, 0, 0, 5, 7, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 5, 7, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 5, 6, 0, 0, 0));
        // Test plan 4: bounded instance [2,10] with clamped loads.
        tbl.push_back(row(1, 0, 1, 14, 0, 0, 0, 9, 10, 0, 0, 1));
        tbl.push_back(row(1, 0, 1, 0, 0, 0, 0, 9, 2, 0, 0, 1));
        tbl.push_back(row(1, 0, 0, 0, 1, 0, 0, 9, 2, 0, 0, 1));
        tbl.push_back(row(1, 0, 0, 0, 1, 1, 0, 9, 3, 0, 0, 0));
        tbl.push_back(row(1, 0, 1, 10, 0, 0, 1, 9, 10, 0, 0, 0));
        tbl.push_back(row(1, 0, 0, 0, 1, 1, 1, 9, 2, 0, 1, 0));

        #12;
        o = get_out(0);
        chk("reset.count0", o.c, 0);
        chk("reset.hit0", o.h, 0);
        chk("reset.wrapped0", o.wr, 0);
        chk("reset.sat0", o.sat, 0);
        chk("reset.at_min0", o.amin, 1);
        o = get_out(1);
        chk("reset.count1", o.c, 2);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            v = tbl[n];
            if (v.inst == 0) cycle(v.i, idle);
            else cycle(idle, v.i);
            o = get_out(v.inst);
            chk($sformatf("vec%0d.count", n), o.c, v.c);
            chk($sformatf("vec%0d.match_hit", n), o.h, v.hit);
            chk($sformatf("vec%0d.wrapped", n), o.wr, v.wr);
            chk($sformatf("vec%0d.saturated", n), o.sat, v.sat);
            chk($sformatf("vec%0d.match", n), o.m, v.c == v.i.mv);
            chk($sformatf("vec%0d.at_min", n), o.amin, v.c == LO_B[v.inst]);
            chk($sformatf("vec%0d.at_max", n), o.amax, v.c == HI_B[v.inst]);
        end

        // Async reset mid-cycle at count 6, then resume from 0.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.count0", {29'd0, count0}, 0);
        chk("arst.count1", {28'd0, count1}, 2);
        chk("arst.sat0", sat0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(mk(0, 0, 0, 1, 1, 0, 4, 0), idle);
        chk("arst.resume", {29'd0, count0}, 1);

`ifdef COUNTER_UPDOWN_SAT_IRQ_EN
        cycle(mk(1, 0, 0, 0, 0, 0, 3, 0), idle);
        chk("irq.clear", irq0, 0);
        u = mk(0, 0, 0, 1, 1, 0, 3, 0);
        for (int n = 0; n < 3; n++) cycle(u, idle);
        chk("irq.hit_count", {29'd0, count0}, 3);
        chk("irq.set", irq0, 1);
        u.wm = 1;
        for (int n = 0; n < 4; n++) cycle(u, idle);
        u.ack = 1;
        cycle(u, idle);
        chk("irq.wrap_count", {29'd0, count0}, 0);
        chk("irq.wrap_pulse", wr0, 1);
        chk("irq.set_beats_ack", irq0, 1);
        cycle(mk(0, 0, 0, 0, 0, 1, 3, 1), idle);
        chk("irq.ack_clears", irq0, 0);
        cycle(mk(0, 0, 0, 0, 0, 1, 3, 0), idle);
        chk("irq.stays_clear", irq0, 0);
`endif

        // Randomized run against the behavioural model on both instances.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            cycle(rnd_in(0), rnd_in(1));
            for (int k = 0; k < 2; k++) begin
                o = get_out(k);
                chk($sformatf("rnd%0d.%0d.count", n, k), o.c, m_cnt[k]);
                chk($sformatf("rnd%0d.%0d.match_hit", n, k), o.h, m_hit[k]);
                chk($sformatf("rnd%0d.%0d.wrapped", n, k), o.wr, m_wr[k]);
                chk($sformatf("rnd%0d.%0d.saturated", n, k), o.sat, m_hi[k] || m_lo[k]);
                chk($sformatf("rnd%0d.%0d.match", n, k), o.m, m_cnt[k] == mv_r[k]);
                chk($sformatf("rnd%0d.%0d.at_max", n, k), o.amax, m_cnt[k] == HI_B[k]);
                chk($sformatf("rnd%0d.%0d.at_min", n, k), o.amin, m_cnt[k] == LO_B[k]);
`ifdef COUNTER_UPDOWN_SAT_IRQ_EN
                chk($sformatf("rnd%0d.%0d.irq", n, k), o.irq, m_irq[k]);
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
